// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b - bin, DIGIT bits per clock, LSB chunk first.
// Operands are captured on start. After N = SIZE/DIGIT chunk edges the result
// is published together with a one-cycle done pulse.
module serial_subtractor #(
  parameter int SIZE  = 8,
  parameter int DIGIT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            bin,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] diff,
  output logic            bout
);

  localparam int N  = SIZE / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  logic [SIZE-1:0]       a_q;
  logic [SIZE-1:0]       b_q;
  logic [SIZE-1:0]       res_q;
  logic                  borrow_q;
  logic [CW-1:0]         count_q;
  logic [DIGIT:0]        chunk;
  logic [SIZE+DIGIT-1:0] res_cat;
  logic [SIZE-1:0]       res_nxt;
  logic                  last;

  // One chunk of the borrow chain: {borrow_out, diff_chunk} = x - y - br.
  function automatic logic [DIGIT:0] sub_chunk(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             br);
    return {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, br};
  endfunction

  // Current chunk difference; the new chunk enters the result from the top so
  // that after N shifts the first (LSB) chunk sits at bit 0.
  always_comb begin
    chunk   = sub_chunk(a_q[int'(count_q)*DIGIT +: DIGIT],
                        b_q[int'(count_q)*DIGIT +: DIGIT], borrow_q);
    res_cat = {chunk[DIGIT-1:0], res_q};
    res_nxt = res_cat[SIZE+DIGIT-1:DIGIT];
    last    = (count_q == LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: start is only looked at in IDLE, RUN lasts N edges.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // Operand capture, chunk iteration and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      diff     <= '0;
      bout     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_q      <= a;
          b_q      <= b;
          borrow_q <= bin;
          count_q  <= '0;
          res_q    <= '0;
        end
      end else begin
        borrow_q <= chunk[DIGIT];
        res_q    <= res_nxt;
        count_q  <= last ? '0 : count_q + 1'b1;
        if (last) begin
          diff <= res_nxt;
          bout <= chunk[DIGIT];
          done <= 1'b1;
        end
      end
    end
  end

endmodule
